// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_rx_state_t;

    localparam int UART_DATA_BITS = 8;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, with selectable reset value.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver with a one-entry valid/ready holding register,
// framing-error pulse and sticky overrun flag.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD)
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       IDX_LAST = 3'(UART_DATA_BITS - 1);

    logic rxs;

    // Idle-high line: presetting to 1 keeps reset release from looking like a start bit.
    sync_2ff #(.RESET_VAL(1'b1)) u_sync_rxd (
        .clk_i (CLOCK_50),
        .rst_ni(reset_n),
        .d_i   (rxd),
        .q_o   (rxs)
    );

    uart_rx_state_t              state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [2:0]                  idx_q, idx_d;
    logic [UART_DATA_BITS-1:0]   shift_q, shift_d;
    logic [UART_DATA_BITS-1:0]   data_q, data_d;
    logic                        valid_q, valid_d;
    logic                        ferr_q, ferr_d;
    logic                        ovr_q, ovr_d;
    logic                        bit_tick;
    logic                        byte_done;
    logic                        stop_bad;
    logic                        handshake;

    assign bit_tick = (cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        byte_done = 1'b0;
        stop_bad  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rxs) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    if (!rxs) begin
                        state_d = DATA;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    shift_d[idx_q] = rxs;
                    cnt_d          = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_tick) begin
                    cnt_d = '0;
                    if (rxs) begin
                        byte_done = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        stop_bad = 1'b1;
                        state_d  = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BREAK: begin
                if (rxs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign handshake = valid_q & rx_ready;

    // A completion in the same cycle as a handshake refills the register; set beats clear.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ovr_d   = ovr_q;
        ferr_d  = stop_bad;
        if (handshake) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
        if (byte_done) begin
            if (!valid_q || handshake) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte: directed scenarios plus randomized frames against a byte-queue model.
module tb_uart_rx_byte;
  import uart_pkg::*;

  localparam int CPB = 8;
  // start edge through sync + FSM (3), half bit, then 9 more bits to the stop sample
  localparam int LATENCY = 3 + CPB / 2 + 9 * CPB;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rxd = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
    .CLOCK_50 (clk),
    .reset_n  (reset_n),
    .rxd      (rxd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int         n_tests = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  int         valid_rises = 0;
  int         valid_cycles = 0;
  int         fe_cycles = 0;
  int         pops = 0;
  int unsigned last_rise_cyc = 0;
  int unsigned start_cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // monitor: handshakes pop the expected queue, pulses are counted
  initial begin
    logic       valid_prev;
    logic       ready_prev;
    logic [7:0] data_prev;
    valid_prev = 1'b0;
    ready_prev = 1'b0;
    data_prev  = 8'h00;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (rx_valid) valid_cycles++;
        if (rx_valid && !valid_prev) begin
          valid_rises++;
          last_rise_cyc = cyc;
        end
        if (frame_err) fe_cycles++;
        if (valid_prev && !ready_prev && rx_valid) check_eq("data_stable", rx_data, data_prev);
        if (rx_valid && rx_ready) begin
          check_eq("byte_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            check_eq("byte_value", rx_data, exp_q.pop_front());
            pops++;
          end
        end
      end
      valid_prev = rx_valid;
      ready_prev = rx_ready;
      data_prev  = rx_data;
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rxd = b;
    tick(CPB);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_val);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_val);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_rx_data"}, rx_data, 8'h00);
    check_eq({tag, "_rx_valid"}, rx_valid, 1'b0);
    check_eq({tag, "_frame_err"}, frame_err, 1'b0);
    check_eq({tag, "_overrun"}, overrun, 1'b0);
  endtask

  initial begin
    int v0;
    int f0;
    int vc0;
    int p0;
    int exp_fe;
    int n_good;
    logic [7:0] b;
    logic bad;

    // 1: reset with a toggling line, then idle
    reset_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rxd = i[0];
      tick(1);
    end
    check_outputs_zero("t1_reset");
    rxd = 1'b1;
    tick(2);
    reset_n = 1'b1;
    v0 = valid_rises;
    tick(20);
    check_eq("t1_no_valid", valid_rises - v0, 0);
    check_eq("t1_rx_valid", rx_valid, 1'b0);

    // 2: single byte, one-cycle valid, latency from start edge
    v0 = valid_rises; vc0 = valid_cycles; f0 = fe_cycles;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    tick(4);
    check_eq("t2_valid_rises", valid_rises - v0, 1);
    check_eq("t2_valid_width", valid_cycles - vc0, 1);
    check_eq("t2_latency", last_rise_cyc - start_cyc, LATENCY);
    check_eq("t2_rx_data", rx_data, 8'hA5);
    check_eq("t2_no_frame_err", fe_cycles - f0, 0);
    check_eq("t2_queue_empty", exp_q.size(), 0);

    // 3: overrun with consumer stalled, then drain
    rx_ready = 1'b0;
    v0 = valid_rises;
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1);
    send_frame(8'hF0, 1'b1);
    tick(2);
    check_eq("t3_rx_valid_held", rx_valid, 1'b1);
    check_eq("t3_rx_data_held", rx_data, 8'h0F);
    check_eq("t3_overrun_set", overrun, 1'b1);
    p0 = pops;
    rx_ready = 1'b1;
    tick(3);
    check_eq("t3_one_handshake", pops - p0, 1);
    check_eq("t3_valid_rises", valid_rises - v0, 1);
    check_eq("t3_rx_valid_clear", rx_valid, 1'b0);
    check_eq("t3_overrun_clear", overrun, 1'b0);

    // 4: bad stop bit, held-low line, recovery
    v0 = valid_rises; f0 = fe_cycles;
    send_frame(8'h3C, 1'b0);
    tick(40);
    check_eq("t4_one_frame_err", fe_cycles - f0, 1);
    check_eq("t4_no_valid", valid_rises - v0, 0);
    rxd = 1'b1;
    tick(16);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    tick(4);
    check_eq("t4_rx_data", rx_data, 8'h3C);
    check_eq("t4_queue_empty", exp_q.size(), 0);
    check_eq("t4_no_extra_frame_err", fe_cycles - f0, 1);

    // 5: short glitch on idle line
    v0 = valid_rises; f0 = fe_cycles;
    rxd = 1'b0;
    tick(2);
    rxd = 1'b1;
    tick(20);
    check_eq("t5_no_valid", valid_rises - v0, 0);
    check_eq("t5_no_frame_err", fe_cycles - f0, 0);
    check_eq("t5_state_idle", 32'(dut.state_q), 32'(IDLE));

    // 6: reset during data bit 4 of 8'hFF, then a clean frame
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    rxd = 1'b1;
    tick(4);
    reset_n = 1'b0;
    #1;
    check_outputs_zero("t6_reset");
    tick(2);
    reset_n = 1'b1;
    tick(16);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    tick(4);
    check_eq("t6_rx_data", rx_data, 8'h81);
    check_eq("t6_queue_empty", exp_q.size(), 0);

    // randomized frames: good bytes go to the queue, bad stop bits count as errors
    v0 = valid_rises; f0 = fe_cycles;
    exp_fe = 0;
    n_good = 0;
    for (int k = 0; k < 24; k++) begin
      b   = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 4) == 0);
      if (bad) exp_fe++;
      else begin
        exp_q.push_back(b);
        n_good++;
      end
      send_frame(b, !bad);
      if (bad) begin
        tick($urandom_range(1, 20));
        rxd = 1'b1;
        tick($urandom_range(2, 10));
      end else begin
        tick($urandom_range(0, 6));
      end
    end
    tick(10);
    check_eq("rand_frame_errs", fe_cycles - f0, exp_fe);
    check_eq("rand_valid_rises", valid_rises - v0, n_good);
    check_eq("rand_queue_empty", exp_q.size(), 0);
    check_eq("rand_no_overrun", overrun, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
